// File: rtl/race_pkg.sv
// Shared types and constants for the enemy-lane block.
// Provides the lane state encoding, the visible raster limits, the sprite ROM
// address width and the 8-bit spawn LFSR step function.
package race_pkg;

  typedef enum logic {
    PARKED  = 1'b0,
    DESCEND = 1'b1
  } lane_state_t;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned ROM_AW   = 14;

  // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/enemy_lane_array_if.sv
// Game-control and pixel-stream bundle for enemy_lane_array.
// master: game logic / mixer side (drives tick, enable, collision, speed,
//         raster counters and ROM data; receives sprite pixels and lane status)
// slave : enemy_lane_array itself
interface enemy_lane_array_if #(
  parameter int unsigned N_LANES = 3,
  parameter int unsigned SPEED_W = 3
);

  logic                        tick;
  logic                        enable;
  logic                        collision;
  logic [SPEED_W-1:0]          speed;
  logic [9:0]                  hcount;
  logic [9:0]                  vcount;
  logic [2:0]                  rom_data;
  logic [race_pkg::ROM_AW-1:0] rom_addr;
  logic [2:0]                  pix_data;
  logic                        pix_valid;
  logic [N_LANES-1:0]          active;
  logic [10*N_LANES-1:0]       pos_y;
  logic                        score_inc;

  modport master (
    output tick, enable, collision, speed, hcount, vcount, rom_data,
    input  rom_addr, pix_data, pix_valid, active, pos_y, score_inc
  );

  modport slave (
    input  tick, enable, collision, speed, hcount, vcount, rom_data,
    output rom_addr, pix_data, pix_valid, active, pos_y, score_inc
  );

endinterface

// File: rtl/enemy_lane.sv
// One enemy car lane: PARKED/DESCEND state, y position and the raster hit test.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   i_step          qualifying game tick (tick && enable && !collision)
//   i_park_all      game disabled: park this lane on the next edge
//   i_spawn         selected by the spawner on this step
//   i_speed         pixels per tick (0 treated as 1)
//   i_hcount/vcount raster position
//   o_active        lane is descending
//   o_exit          lane leaves the road on this step (combinational)
//   o_y             current y
//   o_hit, o_row, o_col  raster inside sprite, and offset within the sprite
module enemy_lane
  import race_pkg::*;
#(
  parameter int unsigned LANE_X   = 160,
  parameter int unsigned SPRITE_W = 80,
  parameter int unsigned SPRITE_H = 121,
  parameter int unsigned Y_EXIT   = 600,
  parameter int unsigned Y_PARK   = 620,
  parameter int unsigned SPEED_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_step,
  input  logic               i_park_all,
  input  logic               i_spawn,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic [9:0]         i_hcount,
  input  logic [9:0]         i_vcount,
  output logic               o_active,
  output logic               o_exit,
  output logic [9:0]         o_y,
  output logic               o_hit,
  output logic [10:0]        o_row,
  output logic [10:0]        o_col
);

  localparam logic [10:0] X_L    = 11'(LANE_X);
  localparam logic [10:0] X_R    = 11'(LANE_X + SPRITE_W);
  localparam logic [10:0] H_SPR  = 11'(SPRITE_H);
  localparam logic [10:0] Y_EX11 = 11'(Y_EXIT);
  localparam logic [9:0]  Y_PK10 = 10'(Y_PARK);

  lane_state_t r_state, w_state_nxt;
  logic [9:0]  r_y, w_y_nxt;
  logic [10:0] w_spd, w_y11, w_sum, w_v, w_h;
  logic        w_leaving;

  assign w_spd     = (i_speed == '0) ? 11'd1 : 11'(i_speed);
  assign w_y11     = {1'b0, r_y};
  assign w_sum     = w_y11 + w_spd;
  assign w_leaving = (r_state == DESCEND) && (w_sum >= Y_EX11);
  assign o_exit    = i_step && w_leaving;

  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    if (i_park_all) begin
      w_state_nxt = PARKED;
      w_y_nxt     = Y_PK10;
    end else if (i_step) begin
      case (r_state)
        PARKED: begin
          if (i_spawn) begin
            w_state_nxt = DESCEND;
            w_y_nxt     = '0;
          end
        end
        DESCEND: begin
          if (w_leaving) begin
            w_state_nxt = PARKED;
            w_y_nxt     = Y_PK10;
          end else begin
            w_y_nxt = w_sum[9:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= PARKED;
      r_y     <= Y_PK10;
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
    end
  end

  assign o_active = (r_state == DESCEND);
  assign o_y      = r_y;

  // 11-bit compares so y+SPRITE_H and x+SPRITE_W never wrap.
  assign w_v   = {1'b0, i_vcount};
  assign w_h   = {1'b0, i_hcount};
  assign o_hit = (w_v < 11'(V_ACTIVE)) && (w_h < 11'(H_ACTIVE)) &&
                 (w_v >= w_y11) && (w_v < w_y11 + H_SPR) &&
                 (w_h >= X_L) && (w_h < X_R);
  assign o_row = w_v - w_y11;
  assign o_col = w_h - X_L;

endmodule

// File: rtl/enemy_lane_array.sv
// N_LANES enemy cars on fixed lane x-positions.
// Spawns cars into an LFSR-chosen parked lane after a minimum tick gap, moves
// them down each game tick, retires them past Y_EXIT with a score pulse, and
// merges their sprites (lowest lane wins) into a 2-stage pixel pipeline that
// addresses one shared combinational sprite ROM.
// Ports:
//   clk, reset  clock, asynchronous active-low reset
//   lane_if     enemy_lane_array_if.slave: tick/enable/collision/speed,
//               hcount/vcount, rom_data in; rom_addr, pix_data, pix_valid,
//               active, pos_y, score_inc out
module enemy_lane_array
  import race_pkg::*;
#(
  parameter int unsigned N_LANES    = 3,
  parameter int unsigned LANE_X0    = 160,
  parameter int unsigned LANE_PITCH = 120,
  parameter int unsigned SPRITE_W   = 80,
  parameter int unsigned SPRITE_H   = 121,
  parameter int unsigned Y_EXIT     = 600,
  parameter int unsigned Y_PARK     = 620,
  parameter int unsigned SPEED_W    = 3,
  parameter int unsigned SPAWN_GAP  = 150,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  enemy_lane_array_if.slave lane_if
);

  localparam int unsigned      CNT_W = $clog2(SPAWN_GAP + 1);
  localparam logic [CNT_W-1:0] GAP   = CNT_W'(SPAWN_GAP);

  logic [N_LANES-1:0]    w_active, w_exit, w_hit, w_spawn;
  logic [9:0]            w_y   [N_LANES];
  logic [10:0]           w_row [N_LANES];
  logic [10:0]           w_col [N_LANES];
  logic [10*N_LANES-1:0] w_pos_y;

  logic [7:0]       r_lfsr;
  logic [CNT_W-1:0] r_cnt, w_cnt_inc;
  logic [7:0]       w_target;
  logic             w_step, w_found, w_do_spawn;
  int unsigned      w_idx;
  logic             r_score;

  logic                w_any_hit;
  logic [10:0]         w_row_win, w_col_win;
  logic [ROM_AW-1:0]   w_addr, r_rom_addr;
  logic                r_hit1, r_pix_valid;
  logic [2:0]          r_pix_data;

  assign w_step = lane_if.tick && lane_if.enable && !lane_if.collision;

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    enemy_lane #(
      .LANE_X  (LANE_X0 + gi * LANE_PITCH),
      .SPRITE_W(SPRITE_W),
      .SPRITE_H(SPRITE_H),
      .Y_EXIT  (Y_EXIT),
      .Y_PARK  (Y_PARK),
      .SPEED_W (SPEED_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_step    (w_step),
      .i_park_all(!lane_if.enable),
      .i_spawn   (w_do_spawn && w_spawn[gi]),
      .i_speed   (lane_if.speed),
      .i_hcount  (lane_if.hcount),
      .i_vcount  (lane_if.vcount),
      .o_active  (w_active[gi]),
      .o_exit    (w_exit[gi]),
      .o_y       (w_y[gi]),
      .o_hit     (w_hit[gi]),
      .o_row     (w_row[gi]),
      .o_col     (w_col[gi])
    );
  end

  // Spawner. Eligibility uses the registered state, so a lane exiting on this
  // tick still reads as DESCEND and cannot be re-spawned on the same tick.
  assign w_cnt_inc = (r_cnt == GAP) ? GAP : r_cnt + CNT_W'(1);
  assign w_target  = r_lfsr % 8'(N_LANES);

  always_comb begin
    w_spawn = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      w_idx = (32'(w_target) + k) % N_LANES;
      if (!w_found && !w_active[w_idx]) begin
        w_spawn[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

  assign w_do_spawn = w_step && (w_cnt_inc == GAP) && w_found;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_lfsr  <= LFSR_SEED;
      r_score <= 1'b0;
    end else begin
      r_lfsr  <= lfsr_next(r_lfsr);
      r_score <= |w_exit;
      if (!lane_if.enable) begin
        r_cnt <= '0;
      end else if (w_step) begin
        r_cnt <= w_do_spawn ? '0 : w_cnt_inc;
      end
    end
  end

  always_comb begin
    w_pos_y = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      w_pos_y[10*i +: 10] = w_y[i];
    end
  end

  // Priority merge: lowest lane index wins.
  always_comb begin
    w_any_hit = 1'b0;
    w_row_win = '0;
    w_col_win = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (!w_any_hit && w_hit[i]) begin
        w_any_hit = 1'b1;
        w_row_win = w_row[i];
        w_col_win = w_col[i];
      end
    end
  end

  assign w_addr = ROM_AW'(w_row_win) * ROM_AW'(SPRITE_W) + ROM_AW'(w_col_win);

  // Stage 1 presents the address to the ROM; stage 2 captures its data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rom_addr  <= '0;
      r_hit1      <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
    end else begin
      r_hit1 <= w_any_hit;
      if (w_any_hit) begin
        r_rom_addr <= w_addr;
      end
      r_pix_valid <= r_hit1;
      r_pix_data  <= r_hit1 ? lane_if.rom_data : '0;
    end
  end

  assign lane_if.rom_addr  = r_rom_addr;
  assign lane_if.pix_data  = r_pix_data;
  assign lane_if.pix_valid = r_pix_valid;
  assign lane_if.active    = w_active;
  assign lane_if.pos_y     = w_pos_y;
  assign lane_if.score_inc = r_score;

endmodule

// File: tb/tb_enemy_lane_array.sv
module tb_enemy_lane_array;

  localparam int N   = 3;
  localparam int GAP = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  enemy_lane_array_if #(.N_LANES(N), .SPEED_W(3)) lif ();

  enemy_lane_array #(
    .N_LANES  (N),
    .SPAWN_GAP(GAP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .lane_if(lif.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_fn(input int a);
    return 3'((a ^ (a >> 4) ^ (a >> 9)) & 7);
  endfunction

  assign lif.rom_data = rom_fn(int'(lif.rom_addr));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lfsr_step(input int s);
    int fb;
    fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
    return ((s << 1) | fb) & 255;
  endfunction

  function automatic int lfsr_after(input int n);
    int s;
    s = 'hA5;
    for (int k = 0; k < n; k++) s = lfsr_step(s);
    return s;
  endfunction

  // ---------------- behavioural model ----------------
  int m_y [N];
  bit m_on[N];
  int m_cnt, m_lfsr, m_addr, m_pd;
  bit m_score, m_h1, m_pv;
  int mv_h, mv_v, mv_win, mv_spd, mv_nexit, mv_t, mv_j;
  bit mv_pb[N];
  bit mv_any, mv_done;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_y[i]  = 620;
        m_on[i] = 0;
      end
      m_cnt = 0; m_lfsr = 'hA5; m_score = 0;
      m_addr = 0; m_h1 = 0; m_pv = 0; m_pd = 0;
    end else begin
      // pixel pipeline, from positions before this edge
      mv_h = int'(lif.hcount);
      mv_v = int'(lif.vcount);
      mv_win = -1;
      for (int i = 0; i < N; i++) begin
        if (mv_win < 0 && mv_v < 480 && mv_h < 640 && mv_v >= m_y[i] && mv_v < m_y[i] + 121 &&
            mv_h >= 160 + 120 * i && mv_h < 240 + 120 * i)
          mv_win = i;
      end
      m_pv = m_h1;
      m_pd = m_h1 ? int'(rom_fn(m_addr)) : 0;
      m_h1 = (mv_win >= 0);
      if (mv_win >= 0)
        m_addr = ((mv_v - m_y[mv_win]) * 80 + mv_h - (160 + 120 * mv_win)) & 'h3FFF;

      // game state
      m_score = 0;
      if (!lif.enable) begin
        for (int i = 0; i < N; i++) begin
          m_y[i]  = 620;
          m_on[i] = 0;
        end
        m_cnt = 0;
      end else if (lif.tick && !lif.collision) begin
        mv_spd = (lif.speed == 0) ? 1 : int'(lif.speed);
        mv_any = 0;
        for (int i = 0; i < N; i++) begin
          mv_pb[i] = !m_on[i];
          if (mv_pb[i]) mv_any = 1;
        end
        mv_nexit = 0;
        for (int i = 0; i < N; i++) begin
          if (m_on[i]) begin
            if (m_y[i] + mv_spd >= 600) begin
              m_y[i] = 620; m_on[i] = 0; mv_nexit++;
            end else begin
              m_y[i] = m_y[i] + mv_spd;
            end
          end
        end
        if (m_cnt < GAP) m_cnt++;
        if (m_cnt == GAP && mv_any) begin
          mv_t = m_lfsr % N;
          mv_done = 0;
          for (int k = 0; k < N; k++) begin
            mv_j = (mv_t + k) % N;
            if (!mv_done && mv_pb[mv_j]) begin
              m_on[mv_j] = 1; m_y[mv_j] = 0; mv_done = 1;
            end
          end
          m_cnt = 0;
        end
        m_score = (mv_nexit > 0);
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // posedges since reset release
  int pe_cnt = 0;
  always @(posedge clk) begin
    if (!reset) pe_cnt <= 0;
    else        pe_cnt <= pe_cnt + 1;
  end

  // ---------------- per-cycle compare ----------------
  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("pos_y[%0d]", i), int'(lif.pos_y[10*i +: 10]), m_y[i]);
        chk($sformatf("active[%0d]", i), int'(lif.active[i]), int'(m_on[i]));
      end
      chk("score_inc", int'(lif.score_inc), int'(m_score));
      chk("rom_addr", int'(lif.rom_addr), m_addr);
      chk("pix_valid", int'(lif.pix_valid), int'(m_pv));
      chk("pix_data", int'(lif.pix_data), m_pd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_tick();
    lif.tick = 1'b1;
    @(negedge clk);
    lif.tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_pos_y%0d", tag, i), int'(lif.pos_y[10*i +: 10]), 620);
    chk({tag, "_active"}, int'(lif.active), 0);
    chk({tag, "_rom_addr"}, int'(lif.rom_addr), 0);
    chk({tag, "_pix_valid"}, int'(lif.pix_valid), 0);
    chk({tag, "_pix_data"}, int'(lif.pix_data), 0);
    chk({tag, "_score"}, int'(lif.score_inc), 0);
    chk({tag, "_lfsr"}, int'(dut.r_lfsr), 'hA5);
  endtask

  int L, snap_cnt, rl, rv, rh;
  int snap[N];

  initial begin
    lif.tick = 0; lif.enable = 0; lif.collision = 0; lif.speed = 0;
    lif.hcount = 0; lif.vcount = 0;
    repeat (3) @(negedge clk);
    chk_on = 1;
    chk_reset_vals("rst");
    reset = 1'b1;
    @(negedge clk);

    // spawn after GAP ticks into the LFSR-chosen lane
    lif.enable = 1; lif.speed = 3'd5;
    repeat (GAP - 1) do_tick();
    chk("pre_spawn_active", int'(lif.active), 0);
    L = lfsr_after(pe_cnt) % N;
    lif.tick = 1'b1;
    @(negedge clk);
    lif.tick = 1'b0;
    chk("spawn_active", int'(lif.active), 1 << L);
    chk("spawn_y", int'(lif.pos_y[10*L +: 10]), 0);
    chk("spawn_model_lane", int'(m_on[L]), 1);
    @(negedge clk);
    @(negedge clk);

    // motion to y=100, then a pixel inside that car
    repeat (20) do_tick();
    chk("y_100", int'(lif.pos_y[10*L +: 10]), 100);
    lif.vcount = 10'd102;
    lif.hcount = 10'(160 + 120 * L + 1);
    @(negedge clk);
    @(negedge clk);
    chk("pix_rom_addr", int'(lif.rom_addr), 161);
    chk("pix_valid_lit", int'(lif.pix_valid), 1);
    chk("pix_data_lit", int'(lif.pix_data), int'(rom_fn(161)));
    lif.vcount = 10'd500; lif.hcount = 10'd0;

    // descend to 595 and exit
    repeat (99) do_tick();
    chk("y_595", int'(lif.pos_y[10*L +: 10]), 595);
    lif.tick = 1'b1;
    @(negedge clk);
    lif.tick = 1'b0;
    chk("exit_y", int'(lif.pos_y[10*L +: 10]), 620);
    chk("exit_active", int'(lif.active[L]), 0);
    chk("exit_score_hi", int'(lif.score_inc), 1);
    @(negedge clk);
    chk("exit_score_lo", int'(lif.score_inc), 0);
    @(negedge clk);

    // collision freeze
    for (int i = 0; i < N; i++) snap[i] = m_y[i];
    snap_cnt = m_cnt;
    lif.collision = 1;
    for (int t = 0; t < 10; t++) begin
      lif.vcount = 10'($urandom_range(0, 479));
      lif.hcount = 10'($urandom_range(0, 639));
      do_tick();
    end
    for (int i = 0; i < N; i++)
      chk($sformatf("coll_y%0d", i), int'(lif.pos_y[10*i +: 10]), snap[i]);
    chk("coll_cnt", int'(dut.r_cnt), snap_cnt);
    lif.collision = 0;

    // enable low parks everything on the next edge
    lif.enable = 0;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      chk($sformatf("dis_y%0d", i), int'(lif.pos_y[10*i +: 10]), 620);
    chk("dis_active", int'(lif.active), 0);
    chk("dis_cnt", int'(dut.r_cnt), 0);
    lif.enable = 1;

    // randomized run with a mid-run asynchronous reset
    for (int c = 0; c < 4000; c++) begin
      lif.tick      = ($urandom_range(0, 3) == 0);
      lif.collision = ($urandom_range(0, 15) == 0);
      lif.enable    = ($urandom_range(0, 599) != 0);
      lif.speed     = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        rl = int'($urandom_range(0, N - 1));
        rv = m_y[rl] + int'($urandom_range(0, 130)) - 4;
        rh = 160 + 120 * rl + int'($urandom_range(0, 90)) - 4;
      end else begin
        rv = int'($urandom_range(0, 524));
        rh = int'($urandom_range(0, 799));
      end
      if (rv < 0) rv = 0;
      lif.vcount = 10'(rv);
      lif.hcount = 10'(rh);
      if (c == 2000) begin
        #3;
        reset = 1'b0;
        #1;
        chk_reset_vals("arst");
        @(negedge clk);
        reset = 1'b1;
        chk("arst_release_lfsr", int'(dut.r_lfsr), 'hA5);
      end else begin
        @(negedge clk);
      end
    end

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/enemy_lane_array.md
Name: enemy_lane_array

Overview:
- Parametrised successor to the single-enemy car block.
- Manages N_LANES independent enemy cars on fixed lane x-positions.
- Spawns cars with an LFSR-chosen lane and a minimum spawn gap, moves them down at a programmable speed, parks them off-screen when they exit, and freezes on collision.
- Produces a priority-merged sprite pixel stream for the VGA mixer, driving one shared external car sprite ROM with explicitly computed addresses.

Parameters:
- N_LANES, 3, number of lanes/cars (1..8)
- LANE_X0, 160, x of lane 0 left edge
- LANE_PITCH, 120, x distance between adjacent lanes
- SPRITE_W, 80, sprite width in pixels
- SPRITE_H, 121, sprite height in pixels
- Y_EXIT, 600, y at or beyond which a car is retired
- Y_PARK, 620, off-screen parked y
- SPEED_W, 3, width of speed input
- SPAWN_GAP, 150, minimum ticks between spawns
- LFSR_SEED, 8'hA5, LFSR reset value (must be non-zero)

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle game-logic strobe (once per frame, asserted in vblank)
- enable  in  1  game running; low parks all cars
- collision  in  1  player hit; freezes motion and spawning while high
- speed  in  SPEED_W  pixels per tick; 0 treated as 1
- hcount  in  10  VGA horizontal count
- vcount  in  10  VGA vertical count
- rom_data  in  3  sprite ROM pixel (combinational ROM)
- rom_addr  out  14  sprite ROM address
- pix_data  out  3  sprite pixel RGB
- pix_valid  out  1  pix_data belongs to a car
- active  out  N_LANES  lane i car on road
- pos_y  out  10*N_LANES  lane i y at bits [10i+9:10i]
- score_inc  out  1  one-cycle pulse when at least one car exits

Behaviour:
- Reset (async, reset=0):
  - all lanes PARKED, pos_y=Y_PARK, active=0, spawn counter=0, LFSR=LFSR_SEED.
  - rom_addr=0, pix_data=0, pix_valid=0, score_inc=0.
- Lane FSM, PARKED/DESCEND, updates only on tick && enable && !collision:
  - DESCEND: if y+spd >= Y_EXIT (11-bit arithmetic) -> y=Y_PARK, go to PARKED, flag exit; else y += spd.
  - spd = (speed==0) ? 1 : speed.
  - PARKED -> DESCEND only when selected by the spawner: y=0.
- Spawner:
  - On a qualifying tick, the spawn counter increments and saturates at SPAWN_GAP.
  - If counter==SPAWN_GAP and any lane was PARKED before this tick: target = lfsr[7:0] mod N_LANES.
  - If the target is busy, take the next PARKED lane scanning upward with wrap.
  - Spawned lane gets y=0; counter clears to 0.
  - A lane exiting on the same tick is not eligible to spawn on that tick.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every clk cycle.
- score_inc: registered; high for exactly the cycle after a tick in which one or more cars exited.
- enable=0: next clk edge parks all lanes (y=Y_PARK) and clears the spawn counter, regardless of tick and collision.
- collision=1 with enable=1: all positions, the counter and states hold; the pixel path continues.
- active[i] = lane i in DESCEND.
- Pixel path:
  - Lane i x = LANE_X0 + i*LANE_PITCH.
  - hit_i = vcount<480 && hcount<640 && y_i <= vcount < y_i+SPRITE_H && x_i <= hcount < x_i+SPRITE_W, compared at 11 bits.
  - Lowest hit index wins.
  - Stage 1 (registered): rom_addr = (vcount-y_win)*SPRITE_W + (hcount-x_win); hit flag registered.
  - rom_addr holds its last value when there is no hit.
  - Stage 2 (registered): pix_data = rom_data, pix_valid = stage-1 hit; pix_data=0 when no hit.
  - Latency from hcount/vcount to pix_data/pix_valid is 2 clk.
- Boundaries:
  - Parked cars (y=620) never hit, since vcount<480.
  - Cars partially below row 479 are clipped by the vcount guard.
  - Lane x ranges never overlap for LANE_PITCH >= SPRITE_W.

Decomposition:
- Package race_pkg: lane_state_t enum {PARKED, DESCEND}, H_ACTIVE=640, V_ACTIVE=480, ROM_AW=14.
- Sub-module enemy_lane: one lane FSM, y register and hit/offset compare, generated N_LANES times.
- Spawner, LFSR, priority mux and pixel pipeline live in the top level.

Test Plan:
- Spawn: reset, enable=1, SPAWN_GAP=4, 4 ticks -> on the 4th tick exactly one lane goes active with y=0; the lane matches LFSR mod 3.
- Motion and exit: speed=5, one active lane at y=595 -> next tick y=620, active clears, score_inc high for exactly 1 cycle.
- Pixel: lane 1 at y=100, hcount=281, vcount=102 -> 2 clk later rom_addr (stage 1) = 2*80+1=161, pix_valid=1, pix_data = rom_data.
- Collision: collision=1 across 10 ticks -> pos_y and the spawn counter unchanged; pixels still produced. enable=0 -> all lanes y=620 on the next clk.
- Busy target: lanes 0 and 2 active, LFSR selects lane 0 -> lane 1 spawns. All lanes active -> no spawn, counter stays at SPAWN_GAP.
- Async reset mid-descent: reset low between edges -> outputs immediately at reset values; after release, LFSR=8'hA5.
